// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, branch funct3 codes,
// FSM state encoding and the datapath mux select values.
package riscv_ctrl_pkg;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;
    localparam logic [2:0] F3_BLT = 3'b100;
    localparam logic [2:0] F3_BGE = 3'b101;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_ERROR    = 4'd11
    } state_t;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALU    = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2   = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src(input logic [6:0] op);
        case (op)
            OP_SW:   return IMM_S;
            OP_BR:   return IMM_B;
            OP_JAL:  return IMM_J;
            default: return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/branch_cond.sv
// Branch resolution from funct3 and the ALU flags; also reports whether the funct3 is a
// supported branch so the decoder can trap unsupported ones.
module branch_cond
    import riscv_ctrl_pkg::*;
#(
    parameter bit BRANCH_EXT = 1'b1
) (
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    output logic       taken,
    output logic       legal
);

    always_comb begin
        taken = 1'b0;
        legal = 1'b0;
        case (funct3)
            F3_BEQ: begin legal = 1'b1;       taken = zero;              end
            F3_BNE: begin legal = BRANCH_EXT; taken = BRANCH_EXT & ~zero; end
            F3_BLT: begin legal = BRANCH_EXT; taken = BRANCH_EXT & lt;    end
            F3_BGE: begin legal = BRANCH_EXT; taken = BRANCH_EXT & ~lt;   end
            default: ;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Control FSM for the multi-cycle RV32I core over a shared memory port.
// state    | meaning
// FETCH    | read instruction at PC, PC+4 into PC when memory is ready
// DECODE   | dispatch on opcode, branch/jal target into ALUOut
// MEMADR   | rs1 + imm address into ALUOut
// MEMREAD  | load access, held until ready
// MEMWB    | load data to rd
// MEMWRITE | store access, held until ready
// EXECR/I  | register / immediate ALU op
// ALUWB    | ALUOut to rd
// JAL      | jump target into PC, OldPC+4 into ALUOut
// BRANCH   | compare rs1/rs2, PC write if taken
// ERROR    | illegal instruction trap, left only by reset
module multicycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter bit MEM_HANDSHAKE = 1'b1,
    parameter bit BRANCH_EXT    = 1'b1,
    parameter int CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             lt,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             PCWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic [1:0]       ResultSrc,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ALUOp,
    output logic [1:0]       ImmSrc,
    output logic             illegal,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] instret
);

    state_t           state;
    state_t           state_nxt;
    logic             illegal_q;
    logic [CNT_W-1:0] instret_q;
    logic             ready;
    logic             br_taken;
    logic             br_legal;
    logic             retire;

    assign ready = mem_ready | ~MEM_HANDSHAKE;

    branch_cond #(.BRANCH_EXT(BRANCH_EXT)) u_branch_cond (
        .funct3 (funct3),
        .zero   (zero),
        .lt     (lt),
        .taken  (br_taken),
        .legal  (br_legal)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH:    if (ready) state_nxt = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_nxt = S_MEMADR;
                    OP_R:         state_nxt = S_EXECR;
                    OP_I:         state_nxt = S_EXECI;
                    OP_BR:        state_nxt = br_legal ? S_BRANCH : S_ERROR;
                    OP_JAL:       state_nxt = S_JAL;
                    default:      state_nxt = S_ERROR;
                endcase
            end
            S_MEMADR:   state_nxt = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  if (ready) state_nxt = S_MEMWB;
            S_MEMWB:    state_nxt = S_FETCH;
            S_MEMWRITE: if (ready) state_nxt = S_FETCH;
            S_EXECR,
            S_EXECI:    state_nxt = S_ALUWB;
            S_ALUWB:    state_nxt = S_FETCH;
            S_JAL:      state_nxt = S_ALUWB;
            S_BRANCH:   state_nxt = S_FETCH;
            S_ERROR:    state_nxt = S_ERROR;
            default:    state_nxt = S_ERROR;
        endcase
    end

    // FETCH is re-entered only from the last state of each instruction class
    assign retire = (state_nxt == S_FETCH) &&
                    (state inside {S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH});

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            illegal_q <= 1'b0;
            instret_q <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt == S_ERROR) illegal_q <= 1'b1;
            if (retire) instret_q <= instret_q + CNT_W'(1);
        end
    end

    // Enables depend on mem_ready / branch flags in the same cycle, so outputs are decoded here
    always_comb begin
        mem_req   = 1'b0;
        PCWrite   = 1'b0;
        AdrSrc    = 1'b0;
        MemWrite  = 1'b0;
        IRWrite   = 1'b0;
        RegWrite  = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        ALUOp     = ALUOP_ADD;
        ImmSrc    = IMM_I;
        illegal   = 1'b0;
        state_o   = 4'd0;
        instret   = '0;
        if (!reset) begin
            ImmSrc  = imm_src(opcode);
            illegal = illegal_q;
            state_o = state;
            instret = instret_q;
            case (state)
                S_FETCH: begin
                    mem_req   = 1'b1;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALU;
                    IRWrite   = ready;
                    PCWrite   = ready;
                end
                S_DECODE: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEMADR: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                end
                S_MEMREAD: begin
                    mem_req = 1'b1;
                    AdrSrc  = 1'b1;
                end
                S_MEMWB: begin
                    ResultSrc = RES_RDATA;
                    RegWrite  = 1'b1;
                end
                S_MEMWRITE: begin
                    mem_req  = 1'b1;
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                end
                S_EXECR: begin
                    ALUSrcA = SRCA_RS1;
                    ALUOp   = ALUOP_FUNCT;
                end
                S_EXECI: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                    ALUOp   = ALUOP_FUNCT;
                end
                S_ALUWB:  RegWrite = 1'b1;
                S_JAL: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_FOUR;
                    PCWrite = 1'b1;
                end
                S_BRANCH: begin
                    ALUSrcA = SRCA_RS1;
                    ALUOp   = ALUOP_SUB;
                    PCWrite = br_taken;
                end
                default: ;
            endcase
        end
    end

endmodule
